ram_mfc_controller: RTL and testbench

//  Data-memory slave behind the Processor's Memory stage. Serves word-addressable RAM

---
 rtl/ram_mfc_controller.sv | 105 ++++++++++
 tb/tb_ram_mfc_controller.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_mfc_controller.sv
// Word-addressable data RAM slave with programmable wait states
// and a four-phase MFC handshake toward the Memory stage.
module ram_mfc_controller #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [31:0] ERR_DATA    = 32'hDEADBEEF
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Mem_Request,
  input  logic        Read_H_Write_L,
  input  logic [31:0] Address,
  input  logic [31:0] Data_In,
  output logic [31:0] Data_Out,
  output logic        MFC,
  output logic        Busy,
  output logic        Addr_Error
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    DONE
  } state_t;

  state_t state, state_n;

  logic [3:0]    cnt;
  logic [31:0]   addr_q;
  logic [31:0]   data_q;
  logic          rd_q;
  logic          mfc_n;
  logic          capture;
  logic          in_range;
  logic [AW-1:0] idx;

  logic [31:0] mem [DEPTH];

  assign capture  = (state == IDLE) && Mem_Request;
  assign in_range = (addr_q < 32'(DEPTH));
  assign idx      = addr_q[AW-1:0];
  assign Busy     = (state != IDLE);

  // DONE is held until MFC has been high for at least one cycle,
  // so an early request drop still yields a one-cycle MFC pulse.
  always_comb begin
    state_n = state;
    mfc_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (Mem_Request)
          state_n = (WAIT_STATES == 0) ? ACCESS : WAIT;
      end
      WAIT: begin
        if (cnt <= 4'd1)
          state_n = ACCESS;
      end
      ACCESS: state_n = DONE;
      DONE: begin
        if (MFC && !Mem_Request)
          state_n = IDLE;
        else
          mfc_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      addr_q     <= 32'd0;
      data_q     <= 32'd0;
      rd_q       <= 1'b0;
      Data_Out   <= 32'd0;
      MFC        <= 1'b0;
      Addr_Error <= 1'b0;
    end else begin
      state <= state_n;
      MFC   <= mfc_n;
      if (capture) begin
        addr_q     <= Address;
        data_q     <= Data_In;
        rd_q       <= Read_H_Write_L;
        Addr_Error <= (Address >= 32'(DEPTH));
        cnt        <= 4'(WAIT_STATES);
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (state == ACCESS && rd_q)
        Data_Out <= in_range ? mem[idx] : ERR_DATA;
    end
  end

  // Array has no reset; an aborted write never reaches ACCESS.
  always_ff @(posedge Clock) begin
    if (state == ACCESS && !rd_q && in_range)
      mem[idx] <= data_q;
  end

endmodule

// File: tb/tb_ram_mfc_controller.sv
// Bench for ram_mfc_controller: vector table, hand-written
// corner sequences and random traffic against a word-array model.
module tb_ram_mfc_controller;

  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, rw;
  logic [31:0] addr, din, dout;
  logic        mfc, busy, aerr;

  logic        req0, rw0;
  logic [31:0] addr0, din0, dout0;
  logic        mfc0, busy0, aerr0;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [256];
  logic [31:0] last_do;

  always #5 clk = ~clk;

  ram_mfc_controller #(
    .DEPTH(256), .WAIT_STATES(2), .ERR_DATA(ERR)
  ) u_dut (
    .Clock(clk), .Reset(rst), .Mem_Request(req),
    .Read_H_Write_L(rw), .Address(addr), .Data_In(din),
    .Data_Out(dout), .MFC(mfc), .Busy(busy), .Addr_Error(aerr)
  );

  ram_mfc_controller #(
    .DEPTH(256), .WAIT_STATES(0), .ERR_DATA(ERR)
  ) u_dut0 (
    .Clock(clk), .Reset(rst), .Mem_Request(req0),
    .Read_H_Write_L(rw0), .Address(addr0), .Data_In(din0),
    .Data_Out(dout0), .MFC(mfc0), .Busy(busy0), .Addr_Error(aerr0)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain word array, out-of-range reads give ERR.
  task automatic model_step(input logic rd, input logic [31:0] a,
                            input logic [31:0] d,
                            output logic [31:0] edo, output logic eerr);
    eerr = (a >= 32'd256);
    if (rd) begin
      last_do = eerr ? ERR : model[a[7:0]];
    end else if (!eerr) begin
      model[a[7:0]] = d;
    end
    edo = last_do;
  endtask

  // Called #1 after a posedge; a2 is driven after capture.
  task automatic txn(input logic rd, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] a2,
                     output logic [31:0] got_do, output logic got_err,
                     output int lat);
    req = 1'b1; rw = rd; addr = a; din = d;
    @(posedge clk); #1;
    chk("busy_after_capture", 64'(busy), 64'd1);
    addr = a2; din = $urandom; rw = ~rd;
    lat = 0;
    while (!mfc && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    got_do = dout; got_err = aerr;
    req = 1'b0;
    @(posedge clk); #1;
    chk("mfc_release", 64'(mfc), 64'd0);
    chk("busy_release", 64'(busy), 64'd0);
  endtask

  task automatic run_model(input logic rd, input logic [31:0] a,
                           input logic [31:0] d);
    logic [31:0] edo, gdo;
    logic        eerr, gerr;
    int          lat;
    model_step(rd, a, d, edo, eerr);
    txn(rd, a, d, $urandom, gdo, gerr, lat);
    chk("latency", 64'(lat), 64'd4);
    chk("data_out", 64'(gdo), 64'(edo));
    chk("addr_error", 64'(gerr), 64'(eerr));
  endtask

  typedef struct {
    logic        rd;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_do;
    logic        exp_err;
  } vec_t;

  vec_t tbl [11];

  initial begin
    logic [31:0] gdo, edo;
    logic        gerr, eerr;
    int          lat;
    logic        r;
    logic [31:0] a;

    tbl[0]  = '{1'b1, 32'd0,        32'd0,        32'h10000000, 1'b0};
    tbl[1]  = '{1'b0, 32'd3,        32'hCAFE0001, 32'h10000000, 1'b0};
    tbl[2]  = '{1'b1, 32'd3,        32'd0,        32'hCAFE0001, 1'b0};
    tbl[3]  = '{1'b1, 32'd256,      32'd0,        32'hDEADBEEF, 1'b1};
    tbl[4]  = '{1'b0, 32'd300,      32'h12345678, 32'hDEADBEEF, 1'b1};
    tbl[5]  = '{1'b1, 32'd44,       32'd0,        32'h1000002C, 1'b0};
    tbl[6]  = '{1'b1, 32'd255,      32'd0,        32'h100000FF, 1'b0};
    tbl[7]  = '{1'b0, 32'd255,      32'hAAAA5555, 32'h100000FF, 1'b0};
    tbl[8]  = '{1'b1, 32'd255,      32'd0,        32'hAAAA5555, 1'b0};
    tbl[9]  = '{1'b1, 32'hFFFFFFFF, 32'd0,        32'hDEADBEEF, 1'b1};
    tbl[10] = '{1'b1, 32'd7,        32'd0,        32'h10000007, 1'b0};

    rst = 1'b1;
    req = 1'b0; rw = 1'b0; addr = '0; din = '0;
    req0 = 1'b0; rw0 = 1'b0; addr0 = '0; din0 = '0;
    last_do = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_data_out", 64'(dout), 64'd0);
    chk("reset_mfc", 64'(mfc), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_addr_error", 64'(aerr), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 256; i++)
      run_model(1'b0, 32'(i), 32'h10000000 + 32'(i));

    for (int i = 0; i < 11; i++) begin
      model_step(tbl[i].rd, tbl[i].a, tbl[i].d, edo, eerr);
      txn(tbl[i].rd, tbl[i].a, tbl[i].d, tbl[i].a ^ 32'h2,
          gdo, gerr, lat);
      chk($sformatf("tbl%0d_latency", i), 64'(lat), 64'd4);
      chk($sformatf("tbl%0d_data_out", i), 64'(gdo),
          64'(tbl[i].exp_do));
      chk($sformatf("tbl%0d_addr_error", i), 64'(gerr),
          64'(tbl[i].exp_err));
    end

    // Address moves from 7 to 9 while waiting
    model_step(1'b1, 32'd7, 32'd0, edo, eerr);
    txn(1'b1, 32'd7, 32'd0, 32'd9, gdo, gerr, lat);
    chk("addr_change_data", 64'(gdo), 64'h10000007);

    // Reset during WAIT of a write to 5 aborts it
    req = 1'b1; rw = 1'b0; addr = 32'd5; din = 32'h11;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #2;
    chk("abort_mfc", 64'(mfc), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_data_out", 64'(dout), 64'd0);
    req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    last_do = 32'd0;
    repeat (4) begin
      @(posedge clk); #1;
      chk("abort_mfc_quiet", 64'(mfc), 64'd0);
    end
    model_step(1'b1, 32'd5, 32'd0, edo, eerr);
    txn(1'b1, 32'd5, 32'd0, 32'd5, gdo, gerr, lat);
    chk("abort_read5", 64'(gdo), 64'h10000005);

    // Request dropped one cycle after capture
    req = 1'b1; rw = 1'b1; addr = 32'd10; din = 32'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    req = 1'b0;
    lat = 1;
    while (!mfc && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("drop_latency", 64'(lat), 64'd4);
    chk("drop_data", 64'(dout), 64'h1000000A);
    @(posedge clk); #1;
    chk("drop_pulse_end", 64'(mfc), 64'd0);
    chk("drop_idle", 64'(busy), 64'd0);
    last_do = 32'h1000000A;

    // Zero wait states: write then read addr 0, held high
    req0 = 1'b1; rw0 = 1'b0; addr0 = 32'd0; din0 = 32'h0BADF00D;
    @(posedge clk); #1;
    lat = 0;
    while (!mfc0 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("ws0_write_latency", 64'(lat), 64'd2);
    req0 = 1'b0;
    @(posedge clk); #1;
    chk("ws0_write_release", 64'(mfc0), 64'd0);
    req0 = 1'b1; rw0 = 1'b1; addr0 = 32'd0;
    @(posedge clk); #1;
    lat = 0;
    while (!mfc0 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("ws0_read_latency", 64'(lat), 64'd2);
    chk("ws0_read_data", 64'(dout0), 64'h0BADF00D);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("ws0_mfc_held", 64'(mfc0), 64'd1);
    end
    req0 = 1'b0;
    @(posedge clk); #1;
    chk("ws0_mfc_fall", 64'(mfc0), 64'd0);

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      r = 1'($urandom);
      if ($urandom_range(0, 3) != 0)
        a = 32'($urandom_range(0, 255));
      else if ($urandom_range(0, 1) != 0)
        a = 32'($urandom_range(256, 300));
      else
        a = $urandom | 32'h100;
      run_model(r, a, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got hang expected finish");
    $fatal(1);
  end

endmodule
